// File: rtl/seg7_bcd_scanner_if.sv
// seg7_bcd_scanner_if: control and display bus of the BCD scanner
// master drives en/up/clr/load/load_val and observes count/carry/digit outputs;
// slave is the scanner side.
interface seg7_bcd_scanner_if #(
    parameter int NDIG = 4
);
    logic              en_i;
    logic              up_i;
    logic              clr_i;
    logic              load_i;
    logic [4*NDIG-1:0] load_val_i;
    logic [4*NDIG-1:0] count_o;
    logic              carry_o;
    logic [3:0]        digit_bcd_o;
    logic [NDIG-1:0]   digit_sel_o;
    modport master (
        output en_i, up_i, clr_i, load_i, load_val_i,
        input  count_o, carry_o, digit_bcd_o, digit_sel_o
    );
    modport slave (
        input  en_i, up_i, clr_i, load_i, load_val_i,
        output count_o, carry_o, digit_bcd_o, digit_sel_o
    );
endinterface

// File: rtl/seg7_bcd_scanner.sv
// seg7_bcd_scanner: prescaled BCD up/down counter with time-multiplexed digit scan
// Ports: wb_clk_i clock, wb_rst_n_i async active-low reset, bus (slave modport):
//   en_i/up_i/clr_i/load_i/load_val_i in; count_o/carry_o/digit_bcd_o/digit_sel_o out.
// Macro SEG7_BLANK_EN: blank leading-zero digits (never digit 0) as 4'hF.
module seg7_bcd_scanner #(
    parameter int CLK_DIV  = 25000,
    parameter int SCAN_DIV = 250,
    parameter int NDIG     = 4
) (
    input logic               wb_clk_i,
    input logic               wb_rst_n_i,
    seg7_bcd_scanner_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NDIG - 1);
    logic [NDIG-1:0][3:0] count_q, count_d, inc_v, dec_v, ld_v;
    logic [DW-1:0]        div_q, div_d;
    logic [SW-1:0]        scan_q, scan_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NDIG-1:0]      sel_q, sel_d, blank;
    logic [3:0]           bcd_q, bcd_d;
    logic                 carry_q, carry_d, tick, inc_wrap, dec_wrap;
    always_comb begin
        logic c, b;
        c = 1'b1;
        b = 1'b1;
        inc_v = count_q;
        dec_v = count_q;
        ld_v  = '0;
        // Ripple carry/borrow; the final c/b flag means every digit wrapped.
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                inc_v[i] = count_q[i] == 4'd9 ? 4'd0 : count_q[i] + 4'd1;
                c = count_q[i] == 4'd9;
            end
            if (b) begin
                dec_v[i] = count_q[i] == 4'd0 ? 4'd9 : count_q[i] - 4'd1;
                b = count_q[i] == 4'd0;
            end
            ld_v[i] = bus.load_val_i[4*i +: 4] > 4'd9 ? 4'd0 : bus.load_val_i[4*i +: 4];
        end
        inc_wrap = c;
        dec_wrap = b;
    end
    always_comb begin
        blank = '0;
`ifdef SEG7_BLANK_EN
        begin
            logic z;
            z = 1'b1;
            // A digit blanks only when it and every more significant digit are zero.
            for (int i = NDIG - 1; i > 0; i--) begin
                z = z && count_q[i] == 4'd0;
                blank[i] = z;
            end
        end
`endif
    end
    assign tick    = bus.en_i && div_q == DIV_MAX;
    assign div_d   = (bus.clr_i || bus.load_i) ? '0 :
                     !bus.en_i ? div_q : (div_q == DIV_MAX ? '0 : div_q + DW'(1));
    assign count_d = bus.clr_i ? '0 : bus.load_i ? ld_v :
                     tick ? (bus.up_i ? inc_v : dec_v) : count_q;
    assign carry_d = !bus.clr_i && !bus.load_i && tick && (bus.up_i ? inc_wrap : dec_wrap);
    assign scan_d  = scan_q == SCAN_MAX ? '0 : scan_q + SW'(1);
    assign idx_d   = scan_q != SCAN_MAX ? idx_q : (idx_q == IDX_MAX ? '0 : idx_q + IW'(1));
    // Strobe and digit value both come from idx_q so they stay aligned.
    assign sel_d   = NDIG'(1) << idx_q;
    assign bcd_d   = blank[idx_q] ? 4'hF : count_q[idx_q];
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            count_q <= '0;
            div_q   <= '0;
            carry_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            sel_q   <= NDIG'(1);
            bcd_q   <= 4'd0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            carry_q <= carry_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
        end
    end
    assign bus.count_o     = count_q;
    assign bus.carry_o     = carry_q;
    assign bus.digit_sel_o = sel_q;
    assign bus.digit_bcd_o = bcd_q;
endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// tb_seg7_bcd_scanner: directed self-checking bench (CLK_DIV=4, SCAN_DIV=2, NDIG=4)
module tb_seg7_bcd_scanner;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] d1234 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    logic [3:0] d7 [4];
    logic [3:0] bl;
    seg7_bcd_scanner_if #(.NDIG(4)) bus ();
    seg7_bcd_scanner #(.CLK_DIV(4), .SCAN_DIV(2), .NDIG(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
`ifdef SEG7_BLANK_EN
        bl = 4'hF;
`else
        bl = 4'h0;
`endif
        d7 = '{4'd7, bl, bl, bl};
        rst_n = 1'b1;
        bus.en_i = 1'b0; bus.up_i = 1'b1; bus.clr_i = 1'b0;
        bus.load_i = 1'b0; bus.load_val_i = '0;
        #1 rst_n = 1'b0;
        step(2);
        chk("rst_count", bus.count_o, 16'h0000);
        chk("rst_carry", 16'(bus.carry_o), 16'h0);
        chk("rst_sel", 16'(bus.digit_sel_o), 16'h1);
        chk("rst_bcd", 16'(bus.digit_bcd_o), 16'h0);
        // 1: free count up, one step per 4 clocks
        rst_n = 1'b1; bus.en_i = 1'b1; bus.up_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            chk("up_count", bus.count_o, 16'(((i / 4) / 10) * 16 + (i / 4) % 10));
        end
        // 2: up wrap
        bus.load_i = 1'b1; bus.load_val_i = 16'h9998;
        step(1); bus.load_i = 1'b0;
        chk("ld9998", bus.count_o, 16'h9998);
        step(4);
        chk("up_9999", bus.count_o, 16'h9999);
        chk("up_9999_carry", 16'(bus.carry_o), 16'h0);
        step(4);
        chk("up_wrap", bus.count_o, 16'h0000);
        chk("up_wrap_carry", 16'(bus.carry_o), 16'h1);
        step(1);
        chk("up_carry_drop", 16'(bus.carry_o), 16'h0);
        // 3: down wrap and invalid digit load
        bus.load_i = 1'b1; bus.load_val_i = 16'h0001; bus.up_i = 1'b0;
        step(1); bus.load_i = 1'b0;
        chk("ld0001", bus.count_o, 16'h0001);
        step(4);
        chk("dn_0000", bus.count_o, 16'h0000);
        chk("dn_0000_carry", 16'(bus.carry_o), 16'h0);
        step(4);
        chk("dn_wrap", bus.count_o, 16'h9999);
        chk("dn_wrap_carry", 16'(bus.carry_o), 16'h1);
        step(1);
        chk("dn_carry_drop", 16'(bus.carry_o), 16'h0);
        bus.load_i = 1'b1; bus.load_val_i = 16'h00A5;
        step(1); bus.load_i = 1'b0;
        chk("ld00A5", bus.count_o, 16'h0005);
        // 4: clr beats load, then en_i=0 holds
        bus.clr_i = 1'b1; bus.load_i = 1'b1; bus.load_val_i = 16'h1234;
        step(1); bus.clr_i = 1'b0; bus.load_i = 1'b0; bus.en_i = 1'b0;
        chk("clr_over_load", bus.count_o, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("hold_carry", 16'(bus.carry_o), 16'h0);
        end
        chk("hold_count", bus.count_o, 16'h0000);
        // 5: scan of 1234, aligned to a fresh reset release
        rst_n = 1'b0;
        bus.load_i = 1'b1; bus.load_val_i = 16'h1234;
        step(1); rst_n = 1'b1;
        step(1); bus.load_i = 1'b0;
        chk("ld1234", bus.count_o, 16'h1234);
        for (int n = 2; n <= 13; n++) begin
            step(1);
            chk("scan_sel", 16'(bus.digit_sel_o), 16'(4'b0001 << (((n - 1) / 2) % 4)));
            chk("scan_bcd", 16'(bus.digit_bcd_o), 16'(d1234[((n - 1) / 2) % 4]));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", 16'(bus.digit_sel_o), 16'h1);
        chk("arst_bcd", 16'(bus.digit_bcd_o), 16'h0);
        chk("arst_count", bus.count_o, 16'h0000);
        // 6: scan of 0007, leading-zero behaviour
        bus.load_i = 1'b1; bus.load_val_i = 16'h0007;
        step(1); rst_n = 1'b1;
        step(1); bus.load_i = 1'b0;
        chk("ld0007", bus.count_o, 16'h0007);
        for (int n = 2; n <= 9; n++) begin
            step(1);
            chk("blank_sel", 16'(bus.digit_sel_o), 16'(4'b0001 << (((n - 1) / 2) % 4)));
            chk("blank_bcd", 16'(bus.digit_bcd_o), 16'(d7[((n - 1) / 2) % 4]));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
